// File: rtl/alarm_clock.sv
// -----------------------------------------------------------------------------
// alarm_clock
//
// Single-clock time-of-day core with an integrated alarm.  Contains the
// seconds prescaler, the hh:mm:ss counter, the set/edit logic for both the
// time and the alarm, the alarm/chime alert timer and the BCD display
// conversion (24-hour or 12-hour with pm flag).
//
// Parameters
//   TICKS_PER_SEC  clk cycles per one-second tick (>= 2)
//   H12            1 = 12-hour display with pm flag, 0 = 24-hour display
//   ALERT_SECS     seconds the alarm stays asserted without ack (1..255)
//   CHIME          1 = one-second alert pulse at every hour rollover
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   mode      in   00 run, 01 set time, 10 set alarm, 11 run
//   turn      in   level; each rising edge advances the edit field
//   change    in   level; each rising edge increments the edit field
//   alarm_en  in   arms the alarm; low also silences an active alert
//   ack       in   high clears an active alert
//   hour      out  BCD hour (00-23, or 01-12 when H12=1)
//   minute    out  BCD minute 00-59
//   second    out  BCD second 00-59
//   sel       out  current edit field: 0 hour, 1 minute, 2 second
//   pm        out  PM flag (H12=1 only, else 0)
//   alert     out  registered buzzer drive
// -----------------------------------------------------------------------------
module alarm_clock #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter bit H12           = 1'b0,
    parameter int ALERT_SECS    = 60,
    parameter bit CHIME         = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       turn,
    input  logic       change,
    input  logic       alarm_en,
    input  logic       ack,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic [1:0] sel,
    output logic       pm,
    output logic       alert
);

    localparam int              PW             = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PRESC_MAX      = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]      ALERT_LOAD     = 8'(ALERT_SECS);
    localparam logic [1:0]      MODE_SET_TIME  = 2'b01;
    localparam logic [1:0]      MODE_SET_ALARM = 2'b10;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    function automatic logic [4:0] inc_hour(input logic [4:0] v);
        return (v >= 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] inc_min_sec(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    // Binary 0..59 to two BCD digits by repeated subtraction of ten.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 5; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    t_h_q, t_h_d;
    logic [5:0]    t_m_q, t_m_d;
    logic [5:0]    t_s_q, t_s_d;
    logic [4:0]    a_h_q, a_h_d;
    logic [5:0]    a_m_q, a_m_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    mode_q;
    logic          turn_q, change_q;
    logic [7:0]    cnt_q, cnt_d;
    logic          alert_q;

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic       set_time, set_alarm, mode_chg;
    logic       turn_p, change_p, tick;
    logic [4:0] inc_h;
    logic [5:0] inc_m, inc_s;
    logic       alarm_hit, chime_hit;

    always_comb begin
        set_time  = (mode == MODE_SET_TIME);
        set_alarm = (mode == MODE_SET_ALARM);
        mode_chg  = (mode != mode_q);
        // Edges landing on the same edge as a mode switch are dropped.
        turn_p    = turn   & ~turn_q   & ~mode_chg;
        change_p  = change & ~change_q & ~mode_chg;
        tick      = ~set_time && (presc_q == PRESC_MAX);
    end

    // Time value that a tick would produce, with carries rippling through.
    always_comb begin
        inc_h = t_h_q;
        inc_m = t_m_q;
        inc_s = inc_min_sec(t_s_q);
        if (t_s_q >= 6'd59) begin
            inc_m = inc_min_sec(t_m_q);
            if (t_m_q >= 6'd59) begin
                inc_h = inc_hour(t_h_q);
            end
        end
    end

    // Trigger conditions evaluate the post-tick time.  tick is already
    // suppressed in set-time mode, so no separate mode qualifier is needed.
    always_comb begin
        alarm_hit = tick && alarm_en && (inc_h == a_h_q) && (inc_m == a_m_q)
                    && (inc_s == 6'd0);
        chime_hit = CHIME && tick && (inc_m == 6'd0) && (inc_s == 6'd0) && ~alert_q;
    end

    always_comb begin
        presc_d = presc_q;
        t_h_d   = t_h_q;
        t_m_d   = t_m_q;
        t_s_d   = t_s_q;
        a_h_d   = a_h_q;
        a_m_d   = a_m_q;
        sel_d   = sel_q;

        if (set_time || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (tick) begin
            t_h_d = inc_h;
            t_m_d = inc_m;
            t_s_d = inc_s;
        end

        if (mode_chg) begin
            sel_d = 2'd0;
        end else if (set_time) begin
            if (turn_p) begin
                sel_d = (sel_q >= 2'd2) ? 2'd0 : sel_q + 2'd1;
            end
            // Field edits wrap without carrying into the next field.
            if (change_p) begin
                case (sel_q)
                    2'd0:    t_h_d = inc_hour(t_h_q);
                    2'd1:    t_m_d = inc_min_sec(t_m_q);
                    default: t_s_d = inc_min_sec(t_s_q);
                endcase
            end
        end else if (set_alarm) begin
            if (turn_p) begin
                sel_d = (sel_q == 2'd0) ? 2'd1 : 2'd0;
            end
            if (change_p) begin
                if (sel_q == 2'd0) begin
                    a_h_d = inc_hour(a_h_q);
                end else begin
                    a_m_d = inc_min_sec(a_m_q);
                end
            end
        end
    end

    // Alert timer: clearing beats a same-cycle trigger, and the alarm beats
    // the chime when both land on the same tick.
    always_comb begin
        cnt_d = cnt_q;
        if (ack || ~alarm_en) begin
            cnt_d = 8'd0;
        end else if (alarm_hit) begin
            cnt_d = ALERT_LOAD;
        end else if (chime_hit) begin
            cnt_d = 8'd1;
        end else if (tick && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q  <= '0;
            t_h_q    <= 5'd0;
            t_m_q    <= 6'd0;
            t_s_q    <= 6'd0;
            a_h_q    <= 5'd0;
            a_m_q    <= 6'd0;
            sel_q    <= 2'd0;
            mode_q   <= 2'd0;
            turn_q   <= 1'b0;
            change_q <= 1'b0;
            cnt_q    <= 8'd0;
            alert_q  <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            t_h_q    <= t_h_d;
            t_m_q    <= t_m_d;
            t_s_q    <= t_s_d;
            a_h_q    <= a_h_d;
            a_m_q    <= a_m_d;
            sel_q    <= sel_d;
            mode_q   <= mode;
            turn_q   <= turn;
            change_q <= change;
            cnt_q    <= cnt_d;
            alert_q  <= (cnt_d != 8'd0);
        end
    end

    // -------------------------------------------------------------------------
    // Display conversion (combinational from registers and mode)
    // -------------------------------------------------------------------------
    logic [4:0] disp_h, hour12;
    logic [5:0] disp_m, disp_s;
    logic       pm_int;

    always_comb begin
        disp_h = t_h_q;
        disp_m = t_m_q;
        disp_s = t_s_q;
        if (set_alarm) begin
            disp_h = a_h_q;
            disp_m = a_m_q;
            disp_s = 6'd0;
        end

        hour12 = disp_h;
        pm_int = 1'b0;
        if (H12) begin
            pm_int = (disp_h >= 5'd12);
            if (disp_h == 5'd0) begin
                hour12 = 5'd12;
            end else if (disp_h > 5'd12) begin
                hour12 = disp_h - 5'd12;
            end
        end

        hour   = to_bcd({1'b0, hour12});
        minute = to_bcd(disp_m);
        second = to_bcd(disp_s);
        pm     = pm_int;
    end

    assign sel   = sel_q;
    assign alert = alert_q;

endmodule

// File: tb/tb_alarm_clock.sv
// -----------------------------------------------------------------------------
// tb_alarm_clock
//
// Directed testbench for alarm_clock with TICKS_PER_SEC=4, ALERT_SECS=2,
// CHIME=1.  A second instance with H12=1 shares every input so the 12-hour
// display can be checked against the same time values.
// -----------------------------------------------------------------------------
module tb_alarm_clock;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       turn;
    logic       change;
    logic       alarm_en;
    logic       ack;

    logic [7:0] hour, minute, second;
    logic [1:0] sel;
    logic       pm, alert;

    logic [7:0] hour_b, minute_b, second_b;
    logic [1:0] sel_b;
    logic       pm_b, alert_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alarm_clock #(
        .TICKS_PER_SEC(4), .H12(1'b0), .ALERT_SECS(2), .CHIME(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .turn(turn), .change(change),
        .alarm_en(alarm_en), .ack(ack), .hour(hour), .minute(minute),
        .second(second), .sel(sel), .pm(pm), .alert(alert)
    );

    alarm_clock #(
        .TICKS_PER_SEC(4), .H12(1'b1), .ALERT_SECS(2), .CHIME(1'b1)
    ) dut12 (
        .clk(clk), .reset(reset), .mode(mode), .turn(turn), .change(change),
        .alarm_en(alarm_en), .ack(ack), .hour(hour_b), .minute(minute_b),
        .second(second_b), .sel(sel_b), .pm(pm_b), .alert(alert_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_change();
        change = 1'b1;
        step(1);
        change = 1'b0;
        step(1);
    endtask

    task automatic pulse_turn();
        turn = 1'b1;
        step(1);
        turn = 1'b0;
        step(1);
    endtask

    task automatic reset_dut();
        mode   = 2'b00;
        turn   = 1'b0;
        change = 1'b0;
        ack    = 1'b0;
        reset  = 1'b0;
        step(2);
        reset  = 1'b1;
    endtask

    // Starts from 00:00:00 with sel=0; leaves the block in set-time mode.
    task automatic set_time_fields(input int h, input int m, input int s);
        mode = 2'b01;
        step(1);
        repeat (h) pulse_change();
        pulse_turn();
        repeat (m) pulse_change();
        pulse_turn();
        repeat (s) pulse_change();
        pulse_turn();
    endtask

    // Starts from alarm 00:00; leaves the block in set-alarm mode.
    task automatic set_alarm_fields(input int h, input int m);
        mode = 2'b10;
        step(1);
        repeat (h) pulse_change();
        pulse_turn();
        repeat (m) pulse_change();
        pulse_turn();
    endtask

    task automatic alarm_setup(input logic hold_ack);
        reset_dut();
        alarm_en = 1'b0;
        set_time_fields(7, 29, 0);
        set_alarm_fields(7, 30);
        ack      = hold_ack;
        mode     = 2'b00;
        alarm_en = 1'b1;
        step(1);
    endtask

    task automatic wait_alert(output bit seen);
        int n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 400) begin
            step(1);
            n++;
            if (alert === 1'b1) seen = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int hi;
        int n;

        reset    = 1'b0;
        mode     = 2'b00;
        turn     = 1'b0;
        change   = 1'b0;
        alarm_en = 1'b0;
        ack      = 1'b0;
        #2;

        // Reset state
        check("rst_hour",   32'(hour),   32'h00);
        check("rst_minute", 32'(minute), 32'h00);
        check("rst_second", 32'(second), 32'h00);
        check("rst_sel",    32'(sel),    32'd0);
        check("rst_pm",     32'(pm),     32'd0);
        check("rst_alert",  32'(alert),  32'd0);
        check("rst_hour12", 32'(hour_b), 32'h12);
        check("rst_pm12",   32'(pm_b),   32'd0);
        step(2);
        reset = 1'b1;

        // Edit wrap, sel cycling, held change, edge on mode switch
        mode   = 2'b01;
        change = 1'b1;
        step(1);
        check("edit_on_mode_chg", 32'(hour), 32'h00);
        change = 1'b0;
        step(1);
        pulse_turn();
        check("sel_after_turn1", 32'(sel), 32'd1);
        repeat (5) pulse_change();
        check("minute_set5", 32'(minute), 32'h05);
        pulse_turn();
        check("sel_after_turn2", 32'(sel), 32'd2);
        pulse_turn();
        check("sel_after_turn3", 32'(sel), 32'd0);
        repeat (12) pulse_change();
        check("hour24_at12", 32'(hour),   32'h12);
        check("hour12_at12", 32'(hour_b), 32'h12);
        check("pm12_at12",   32'(pm_b),   32'd1);
        pulse_change();
        check("hour24_at13", 32'(hour),   32'h13);
        check("hour12_at13", 32'(hour_b), 32'h01);
        check("pm12_at13",   32'(pm_b),   32'd1);
        check("pm24_at13",   32'(pm),     32'd0);
        repeat (10) pulse_change();
        check("hour_at23", 32'(hour), 32'h23);
        pulse_change();
        check("hour_wrap",       32'(hour),   32'h00);
        check("minute_no_carry", 32'(minute), 32'h05);
        change = 1'b1;
        step(10);
        change = 1'b0;
        step(1);
        check("held_change_once", 32'(hour),   32'h01);
        check("frozen_second",    32'(second), 32'h00);

        // Rollover and chime: alarm moved to 01:00 during the first second
        reset_dut();
        alarm_en = 1'b1;
        set_time_fields(23, 59, 59);
        check("set_2359_h", 32'(hour),   32'h23);
        check("set_2359_m", 32'(minute), 32'h59);
        check("set_2359_s", 32'(second), 32'h59);
        mode = 2'b10;
        step(1);
        change = 1'b1;
        step(1);
        change = 1'b0;
        mode   = 2'b00;
        step(1);
        check("pre_roll_second", 32'(second), 32'h59);
        check("pre_roll_alert",  32'(alert),  32'd0);
        step(1);
        check("roll_hour",   32'(hour),   32'h00);
        check("roll_minute", 32'(minute), 32'h00);
        check("roll_second", 32'(second), 32'h00);
        check("chime_on",    32'(alert),  32'd1);
        check("roll_hour12", 32'(hour_b), 32'h12);
        check("roll_pm12",   32'(pm_b),   32'd0);
        step(3);
        check("chime_still_on", 32'(alert), 32'd1);
        step(1);
        check("chime_off", 32'(alert), 32'd0);

        // Alarm with timeout
        alarm_setup(1'b0);
        wait_alert(seen);
        check("alarm_seen",   32'(seen),   32'd1);
        check("alarm_hour",   32'(hour),   32'h07);
        check("alarm_minute", 32'(minute), 32'h30);
        check("alarm_second", 32'(second), 32'h00);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (alert === 1'b1) hi++;
            step(1);
        end
        check("alarm_len", 32'(hi), 32'd8);

        // Alarm acknowledged
        alarm_setup(1'b0);
        wait_alert(seen);
        check("ack_alarm_seen", 32'(seen), 32'd1);
        step(2);
        check("ack_before", 32'(alert), 32'd1);
        ack = 1'b1;
        step(1);
        check("ack_cleared", 32'(alert), 32'd0);
        ack = 1'b0;
        step(1);
        check("ack_stays_clear", 32'(alert), 32'd0);

        // alarm_en dropped during alert
        alarm_setup(1'b0);
        wait_alert(seen);
        check("en_alarm_seen", 32'(seen), 32'd1);
        step(1);
        alarm_en = 1'b0;
        step(1);
        check("en_drop_clear", 32'(alert), 32'd0);
        alarm_en = 1'b1;
        step(8);
        check("en_drop_stays", 32'(alert), 32'd0);

        // Trigger coinciding with ack
        alarm_setup(1'b1);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 400) begin
            step(1);
            n++;
            if (minute === 8'h30) seen = 1'b1;
        end
        check("prio_reached", 32'(seen),   32'd1);
        check("prio_second",  32'(second), 32'h00);
        check("prio_alert",   32'(alert),  32'd0);
        ack = 1'b0;
        step(2);
        check("prio_after_ack", 32'(alert), 32'd0);

        // Asynchronous reset mid-count, then first ticks
        mode = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_hour",   32'(hour),   32'h00);
        check("async_minute", 32'(minute), 32'h00);
        check("async_second", 32'(second), 32'h00);
        check("async_sel",    32'(sel),    32'd0);
        check("async_alert",  32'(alert),  32'd0);
        check("async_hour12", 32'(hour_b), 32'h12);
        step(1);
        reset = 1'b1;
        step(3);
        check("tick_not_yet", 32'(second), 32'h00);
        step(1);
        check("first_tick", 32'(second), 32'h01);
        step(4);
        check("second_tick", 32'(second), 32'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_clock.md
# alarm_clock

Parametrised single-clock time-of-day core with an integrated alarm. It merges the prescaler, hh:mm:ss counter and set/control logic into one block, and adds the features the first-generation clock lacks: configurable tick rate, 12/24-hour display, a programmable alarm with acknowledge and timeout, and an optional hourly chime. It sits directly under the board top and drives the display decoder and buzzer.

## Interface
- TICKS_PER_SEC, 50000000: clk cycles per second tick; ≥2.
- H12, 0: 1 = 12-hour display with `pm` flag; 0 = 24-hour display.
- ALERT_SECS, 60: seconds the alarm stays asserted without `ack`; 1..255.
- CHIME, 1: 1 = one-second `alert` pulse at every hour rollover.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- mode  in  2  00 run, 01 set time, 10 set alarm, 11 run (reserved, same as 00).
- turn  in  1  level, synchronous to clk; each rising edge advances the edit field.
- change  in  1  level, synchronous to clk; each rising edge increments the edit field.
- alarm_en  in  1  arms the alarm; low also silences an active alarm.
- ack  in  1  level; high clears an active alert.
- hour  out  8  BCD hour (00–23, or 01–12 when H12=1).
- minute  out  8  BCD minute 00–59.
- second  out  8  BCD second 00–59.
- sel  out  2  current edit field: 0 hour, 1 minute, 2 second.
- pm  out  1  PM flag (H12=1 only, else 0).
- alert  out  1  buzzer drive.

## Operation
- Internal state: binary time t_h (0–23), t_m, t_s (0–59); alarm a_h, a_m; prescaler; sel; alert counter; turn_q/change_q edge registers.
- Prescaler counts 0..TICKS_PER_SEC-1. `tick` is asserted in the cycle the count equals TICKS_PER_SEC-1; the count then wraps to 0.
- Prescaler is held at 0 while mode=01.
- In run mode (00/11), `tick` increments t_s. Carries ripple into t_m and t_h in the same cycle. 23:59:59 wraps to 00:00:00.
- Rising-edge detect: `turn_p = turn & ~turn_q`, `change_p = change & ~change_q`. The edit takes effect on that same clk edge.
- `turn_p` and `change_p` are ignored in run mode.
- Mode 01 (set time):
  - `turn_p` cycles sel 0→1→2→0.
  - `change_p` increments the selected field modulo its range with no carry (hour 23→0, minute/second 59→0).
- Mode 10 (set alarm):
  - Time keeps running.
  - sel cycles 0→1→0 only; `change_p` increments a_h or a_m.
  - Display outputs show a_h:a_m:00.
- Any change of `mode` forces sel to 0 on the next edge.
- Display conversion is combinational from registers.
  - H12=1: t_h 0 shows 12 with pm=0; t_h 1–11 shows 1–11, pm=0; t_h 12 shows 12, pm=1; t_h 13–23 shows 1–11, pm=1.
- Alarm trigger: on a `tick` whose result is t_h=a_h, t_m=a_m, t_s=0, with alarm_en=1 and mode≠01.
  - `alert` asserts and the alert counter loads ALERT_SECS.
  - The counter decrements on each later tick; alert clears when it reaches 0.
- Chime: with CHIME=1 and no alarm active, a tick producing t_m=0, t_s=0 asserts alert for exactly one second (counter loads 1).
  - When the alarm and the chime coincide, the alarm wins.
- Clearing: `ack`=1 or alarm_en=0 clears alert and the counter on the next edge. This takes priority over a same-cycle trigger.
- Reset clears all state: time and alarm 00:00:00 / 00:00, prescaler 0, sel 0, alert 0, edge registers 0.

## Timing
- Output values after reset assertion:
  - hour=8'h00 (8'h12 when H12=1), minute=8'h00, second=8'h00.
  - sel=0, pm=0, alert=0.
  - All take these values immediately and asynchronously.
- First tick comes TICKS_PER_SEC cycles after reset release, or after leaving mode 01.
- Time outputs update on the clk edge at the end of the tick cycle; zero-cycle combinational path to the BCD outputs.
- `alert` is a registered output, high starting the edge that applies the triggering tick.
- Alert duration without ack is ALERT_SECS × TICKS_PER_SEC cycles.
- A held `turn` or `change` produces exactly one edit.
- Edges that arrive in the same cycle as a mode change are ignored.

## Test plan
Unless stated otherwise, TICKS_PER_SEC=4, H12=0, ALERT_SECS=2, CHIME=1.
- **Reset and first tick:** assert reset mid-count → all outputs zero immediately. Release → second=8'h01 exactly 4 cycles later, 8'h02 at 8 cycles.
- **Edit wrap:** mode=01, set hour to 23; pulse change → hour=8'h00, minute unchanged. Three turn pulses → sel 1,2,0. Holding change high for 10 cycles → exactly one increment.
- **Rollover and chime:** set 23:59:59, switch to mode 00 → after 4 cycles 00:00:00 and alert=1 for 4 cycles, then 0.
- **Alarm and timeout:** alarm 07:30, time 07:29:59, alarm_en=1 → alert=1 at 07:30:00 and stays high for 8 cycles. Repeat with ack pulsed 2 cycles after assertion → alert=0 the following cycle.
- **12-hour display:** H12=1; t_h=0 → hour=8'h12, pm=0; t_h=13 → hour=8'h01, pm=1; t_h=12 → hour=8'h12, pm=1.
- **Alarm priority:** a trigger in the same cycle as ack=1 → alert stays 0. alarm_en dropped during alert → alert=0 next edge.
